vga_fb_scheduler: RTL
=====================

# vga_fb_scheduler

Schedules a single shared SRAM port between the VGA display path and a framebuffer writer. It prefetches pixels in row-major order into a small FIFO ahead of `vga_sync`, and holds `vga_sync` in reset-like idle (via `enable`) until the FIFO is primed. Leftover memory bandwidth is granted to the writer. It sits between `vga_sync`, the SRAM controller and whatever draws into the framebuffer.

## Interface
- `ADDR_BITS`, 20: SRAM word address width.
- `DATA_BITS`, 16: pixel/SRAM word width.
- `H_VISIBLE`, 640: visible pixels per line.
- `V_VISIBLE`, 480: visible lines per frame.
- `FIFO_DEPTH`, 8: prefetch FIFO entries (power of 2, ≥ 4).
- `LOW_WATER`, 4: read-urgency threshold (< `FIFO_DEPTH`).

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `vga_visible` in 1: `visible` from `vga_sync`.
- `vga_enable` out 1: drives `vga_sync.enable`.
- `pixel_data` out DATA_BITS: current display pixel.
- `underflow` out 1: sticky; visible pixel requested while FIFO empty.
- `wr_valid` in 1, `wr_addr` in ADDR_BITS, `wr_data` in DATA_BITS: writer request.
- `wr_ready` out 1: writer request accepted this cycle.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out ADDR_BITS, `mem_wdata` out DATA_BITS: SRAM command.
- `mem_ready` in 1: command accepted this cycle.
- `mem_rvalid` in 1, `mem_rdata` in DATA_BITS: in-order read return, any latency ≥ 1.

## Operation
- State:
  - `rd_addr`: next prefetch address, 0..`H_VISIBLE*V_VISIBLE-1`; wraps to 0 after the last pixel.
  - `level`: FIFO occupancy.
  - `pending`: reads accepted but not yet returned.
  - `credit = level + pending`: never exceeds `FIFO_DEPTH`.
- Arbitration, evaluated every cycle:
  - **URGENT_READ**: `credit < LOW_WATER` → read.
  - **WRITE**: otherwise, if `wr_valid` → write.
  - **READ**: otherwise, if `credit < FIFO_DEPTH` → read.
  - **IDLE**: otherwise → `mem_req` = 0.
- Read command: `mem_req`=1, `mem_we`=0, `mem_addr`=`rd_addr`. When accepted (`mem_req & mem_ready`): `rd_addr`++ and `pending`++.
- Write command: `mem_req`=1, `mem_we`=1, `mem_addr`=`wr_addr`, `mem_wdata`=`wr_data`.
  - `wr_ready` = write selected & `mem_ready` (combinational).
  - Writer holds its request stable until `wr_ready`.
- Read return: `mem_rvalid` pushes `mem_rdata` into the FIFO and decrements `pending`.
- Display pop: when `vga_enable & vga_visible & level>0`, pop the FIFO. `pixel_data` is the FIFO head (combinational); it is 0 when the FIFO is empty.
- Underflow: `vga_enable & vga_visible & level==0` sets `underflow`. No pop occurs. The flag clears only on reset.
- Startup: `vga_enable` stays 0 until `level == FIFO_DEPTH`. After that it stays 1 until reset. Writes are serviced during priming.

## Timing
- Reset values: `rd_addr`=0, `level`=0, `pending`=0, `vga_enable`=0, `underflow`=0, `mem_req`=0, `wr_ready`=0, `pixel_data`=0.
- Reset asserted mid-transaction: all state clears immediately. `mem_rvalid` returns for reads issued before reset are ignored until the first new read is accepted after reset; the SRAM controller is reset alongside this block.
- `mem_*` outputs are combinational from registered state, `wr_valid` and `wr_addr`/`wr_data`.
- Push and pop in the same cycle: `level` unchanged; the head advances.
- Accept and return in the same cycle: `pending` unchanged.
- `vga_enable` rises the cycle after `level` reaches `FIFO_DEPTH`. `vga_sync` therefore starts at (0,0) with a full FIFO.
- A write can be starved only while `credit < LOW_WATER`. Once credit recovers, a pending `wr_valid` wins over non-urgent reads.
- `credit` arithmetic: width `$clog2(FIFO_DEPTH)+1`; must not overflow or underflow. Assert this in the bench.

## Test plan
Parameters for all scenarios unless noted: `H_VISIBLE`=4, `V_VISIBLE`=2, `FIFO_DEPTH`=4, `LOW_WATER`=2.

1. Priming: memory with 1-cycle latency and `mem_ready`=1, no writer → reads to addresses 0,1,2,3 on 4 consecutive cycles. `vga_enable` rises the cycle after the 4th return. `underflow`=0.
2. Wrap: memory returning data = address; `vga_visible` pulsed for 10 pops → `pixel_data` sequence is 0,1,…,7,0,1. `rd_addr` wraps 7→0.
3. Write priority: FIFO full, `wr_valid`=1 with `wr_addr`=5, `wr_data`=0xABCD → `wr_ready`=1 the same cycle, with `mem_we`=1, `mem_addr`=5, `mem_wdata`=0xABCD.
4. Urgency: `credit`=1, `wr_valid`=1 → a read is issued and `wr_ready`=0. After credit reaches 2, the write is granted before any further read.
5. Underflow: `mem_ready`=0 after priming, `vga_visible` held high for 5 cycles → 4 pops, then `pixel_data`=0 and `underflow`=1. The flag remains 1 after `mem_ready` returns.
6. Async reset mid-frame: assert `reset` between clock edges with `pending`=2 → all outputs go to their reset values immediately. Priming restarts from address 0.

Source files
------------

// File: rtl/vga_fb_scheduler.sv
// rtl/vga_fb_scheduler.sv - shares one SRAM port between VGA pixel prefetch and a framebuffer writer
module vga_fb_scheduler #(
  parameter int ADDR_BITS  = 20,
  parameter int DATA_BITS  = 16,
  parameter int H_VISIBLE  = 640,
  parameter int V_VISIBLE  = 480,
  parameter int FIFO_DEPTH = 8,
  parameter int LOW_WATER  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vga_visible,
  output logic                 vga_enable,
  output logic [DATA_BITS-1:0] pixel_data,
  output logic                 underflow,
  input  logic                 wr_valid,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 wr_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic                 mem_ready,
  input  logic                 mem_rvalid,
  input  logic [DATA_BITS-1:0] mem_rdata
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] LOW_C = CW'(LOW_WATER);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(H_VISIBLE * V_VISIBLE - 1);

  logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]        head;
  logic [PW-1:0]        tail;
  logic [CW-1:0]        level;
  logic [CW-1:0]        pending;
  logic [CW-1:0]        credit;
  logic [ADDR_BITS-1:0] rd_addr;
  logic                 stale;
  logic                 urgent;
  logic                 sel_write;
  logic                 sel_read;
  logic                 rd_accept;
  logic                 push;
  logic                 pop;
  logic                 starve;

  // Credit counts every slot already spoken for, so reads never overrun the FIFO.
  always_comb begin
    credit    = level + pending;
    urgent    = credit < LOW_C;
    sel_write = !urgent && wr_valid;
    sel_read  = urgent || (!wr_valid && (credit < DEPTH_C));
    mem_req   = !reset && (sel_read || sel_write);
    mem_we    = !reset && sel_write;
    mem_addr  = sel_write ? wr_addr : rd_addr;
    mem_wdata = sel_write ? wr_data : '0;
    wr_ready  = mem_we && mem_ready;
    rd_accept = mem_req && !sel_write && mem_ready;
    push      = mem_rvalid && !stale;
    pop       = vga_enable && vga_visible && (level != '0);
    starve    = vga_enable && vga_visible && (level == '0);
  end

  assign pixel_data = (level != '0) ? fifo_mem[head] : '0;

  // Returns still in flight from before a reset are dropped until the first new read is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr    <= '0;
      level      <= '0;
      pending    <= '0;
      head       <= '0;
      tail       <= '0;
      vga_enable <= 1'b0;
      underflow  <= 1'b0;
      stale      <= 1'b1;
    end else begin
      if (rd_accept) begin
        rd_addr <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + ADDR_BITS'(1);
        stale   <= 1'b0;
      end
      if (rd_accept && !push) begin
        pending <= pending + CW'(1);
      end else if (!rd_accept && push) begin
        pending <= pending - CW'(1);
      end
      if (push) begin
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      if (push && !pop) begin
        level <= level + CW'(1);
      end else if (!push && pop) begin
        level <= level - CW'(1);
      end
      if (level == DEPTH_C) begin
        vga_enable <= 1'b1;
      end
      if (starve) begin
        underflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[tail] <= mem_rdata;
    end
  end
endmodule
